// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
//   DATA_W      payload width in bits
//   FRAME_BITS  line bits per frame: start, parity, DATA_W data bits, stop
//   rx_state_t  receiver frame-tracking states
//   parity_of   parity bit for a payload (payload + parity has even weight)
package serial_receiver_pkg;

    localparam int unsigned DATA_W     = 7;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [2:0] {
        UNARMED,
        IDLE,
        PARITY,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic parity_of(input logic [DATA_W-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/serial_receiver.sv
// Receive side of the single-wire serial link. One line bit is sampled per clk
// cycle (no oversampling). Frame: start, parity, data[0..6] LSB first, stop.
// Ports:
//   clk          rising-edge clock shared with the transmitter
//   rstN         asynchronous active-low reset
//   signalIn     serial line, synchronous to clk
//   dataOut      last received payload (loaded on every completed frame)
//   received     one-cycle strobe when a stop bit has been sampled
//   parityError  parity check result, valid with received, held until the next
//   frameError   stop-level check result, valid with received, held until the next
//   busy         high while a frame is being received (PARITY, DATA, STOP)
// Parameter:
//   START_STOPN  start-bit level; idle and stop level is its complement
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter logic START_STOPN = 1'b0
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              signalIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              received,
    output logic              parityError,
    output logic              frameError,
    output logic              busy
);

    localparam logic STOP_LEVEL = ~START_STOPN;

    rx_state_t         state;
    rx_state_t         state_next;
    logic [2:0]        index;
    logic [DATA_W-1:0] data;
    logic              parity_bit;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= UNARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            // A line parked at start level after reset or a bad stop must
            // first show the idle level before a falling edge counts as start.
            UNARMED: begin
                if (signalIn == STOP_LEVEL) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (signalIn == START_STOPN) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                busy       = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                busy = 1'b1;
                if (index == 3'd6) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                busy       = 1'b1;
                state_next = (signalIn == STOP_LEVEL) ? IDLE : UNARMED;
            end
            default: begin
                state_next = UNARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            index       <= '0;
            data        <= '0;
            parity_bit  <= 1'b0;
            dataOut     <= '0;
            received    <= 1'b0;
            parityError <= 1'b0;
            frameError  <= 1'b0;
        end else begin
            received <= 1'b0;
            unique case (state)
                PARITY: begin
                    parity_bit <= signalIn;
                    index      <= '0;
                end
                DATA: begin
                    data[index] <= signalIn;
                    index       <= index + 3'd1;
                end
                STOP: begin
                    dataOut     <= data;
                    received    <= 1'b1;
                    parityError <= parity_of(data) ^ parity_bit;
                    frameError  <= (signalIn != STOP_LEVEL);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: two instances (start level 0 and 1),
// a frame driver that pushes expected results, and per-instance monitors that
// pop and compare on every received strobe.
module tb_serial_receiver;

    typedef struct {
        logic [6:0] data;
        logic       perr;
        logic       ferr;
        int         edge_no;
    } exp_t;

    logic       clk;
    logic       rstN;
    logic       line0;
    logic       line1;
    logic [6:0] data0;
    logic [6:0] data1;
    logic       rcv0;
    logic       rcv1;
    logic       perr0;
    logic       perr1;
    logic       ferr0;
    logic       ferr1;
    logic       busy0;
    logic       busy1;

    int   cyc;
    int   total;
    int   passed;
    exp_t q0[$];
    exp_t q1[$];

    serial_receiver #(.START_STOPN(1'b0)) dut0 (
        .clk        (clk),
        .rstN       (rstN),
        .signalIn   (line0),
        .dataOut    (data0),
        .received   (rcv0),
        .parityError(perr0),
        .frameError (ferr0),
        .busy       (busy0)
    );

    serial_receiver #(.START_STOPN(1'b1)) dut1 (
        .clk        (clk),
        .rstN       (rstN),
        .signalIn   (line1),
        .dataOut    (data1),
        .received   (rcv1),
        .parityError(perr1),
        .frameError (ferr1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end else begin
            passed++;
        end
    endtask

    // Monitors: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rcv0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("inst0 unexpected received", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("inst0 dataOut", int'(data0), int'(e.data));
                check("inst0 parityError", int'(perr0), int'(e.perr));
                check("inst0 frameError", int'(ferr0), int'(e.ferr));
                check("inst0 received edge", cyc, e.edge_no);
            end
        end
    end

    always @(negedge clk) begin
        if (rcv1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("inst1 unexpected received", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("inst1 dataOut", int'(data1), int'(e.data));
                check("inst1 parityError", int'(perr1), int'(e.perr));
                check("inst1 frameError", int'(ferr1), int'(e.ferr));
                check("inst1 received edge", cyc, e.edge_no);
            end
        end
    end

    task automatic drive(input bit which, input logic level);
        if (which) line1 = level;
        else       line0 = level;
    endtask

    task automatic hold(input bit which, input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(which, level);
        end
    endtask

    // Builds the frame from the link rules and records what the receiver must
    // report: the start bit is sampled one edge after it is driven, and the
    // strobe appears nine edges after that.
    task automatic send_frame(input bit which, input logic [6:0] payload,
                              input bit flip_par, input bit bad_stop);
        logic       start_lvl;
        logic [9:0] bits;
        exp_t       e;
        start_lvl = which ? 1'b1 : 1'b0;
        bits[0]   = start_lvl;
        bits[1]   = logic'($countones(payload) % 2) ^ flip_par;
        for (int i = 0; i < 7; i++) bits[2+i] = payload[i];
        bits[9]   = bad_stop ? start_lvl : ~start_lvl;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check(which ? "inst1 busy mid-frame" : "inst0 busy mid-frame",
                      int'(which ? busy1 : busy0), 1);
            end
            if (i == 0) begin
                e.data    = payload;
                e.perr    = flip_par;
                e.ferr    = bad_stop;
                e.edge_no = cyc + 10;
                if (which) q1.push_back(e);
                else       q0.push_back(e);
            end
            drive(which, bits[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        passed = 0;
        rstN   = 1'b0;
        line0  = 1'b1;
        line1  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dataOut", int'(data0), 0);
        check("reset received", int'(rcv0), 0);
        check("reset parityError", int'(perr0), 0);
        check("reset frameError", int'(ferr0), 0);
        check("reset busy", int'(busy0), 0);
        check("reset inst1 busy", int'(busy1), 0);
        rstN = 1'b1;
        hold(0, 1'b1, 3);

        send_frame(0, 7'h55, 0, 0);
        hold(0, 1'b1, 2);
        send_frame(0, 7'h55, 1, 0);
        hold(0, 1'b1, 2);

        // Bad stop, then line parked at start level: must stay silent.
        send_frame(0, 7'h7F, 0, 1);
        hold(0, 1'b0, 20);
        hold(0, 1'b1, 3);

        send_frame(0, 7'h7F, 0, 0);
        hold(0, 1'b1, 1);
        send_frame(0, 7'h00, 0, 0);
        hold(0, 1'b1, 2);

        send_frame(0, 7'h12, 0, 0);
        send_frame(0, 7'h34, 0, 0);
        hold(0, 1'b1, 2);

        // Reset during data bit 3 of an all-zero payload frame.
        hold(0, 1'b0, 5);
        @(negedge clk);
        check("busy before mid-frame reset", int'(busy0), 1);
        line0 = 1'b0;
        rstN  = 1'b0;
        #1;
        check("mid-frame reset dataOut", int'(data0), 0);
        check("mid-frame reset received", int'(rcv0), 0);
        check("mid-frame reset parityError", int'(perr0), 0);
        check("mid-frame reset frameError", int'(ferr0), 0);
        check("mid-frame reset busy", int'(busy0), 0);
        @(negedge clk);
        rstN = 1'b1;
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 3);
        send_frame(0, 7'h2B, 0, 0);
        hold(0, 1'b1, 2);

        for (int n = 0; n < 20; n++) begin
            send_frame(0, 7'($urandom), ($urandom_range(0, 7) == 0), 0);
            hold(0, 1'b1, $urandom_range(0, 2));
        end
        hold(0, 1'b1, 2);

        send_frame(1, 7'h2A, 0, 0);
        hold(1, 1'b0, 2);
        for (int n = 0; n < 100; n++) begin
            send_frame(1, 7'($urandom), ($urandom_range(0, 7) == 0), 0);
            hold(1, 1'b0, $urandom_range(0, 2));
        end
        hold(1, 1'b0, 15);
        hold(0, 1'b1, 2);

        check("inst0 outstanding frames", q0.size(), 0);
        check("inst1 outstanding frames", q1.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
